// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with registered x/y/valid/hsync/vsync and line/frame strobes.
// Define VIDEO_TIMING_GEN_PATTERN_EN to add an 8-bar colour test pattern on r/g/b.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    ,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Compare limits are 12 bits wide so a 2048 end value never wraps to 0.
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h, v;
    logic [10:0] h_nxt, v_nxt;
    logic [11:0] h_w, v_w;
    logic        v_act;
    logic        valid_d, hsync_d, vsync_d, line_d, frame_d;
    logic [10:0] x_d;
    logic [9:0]  y_d;

    assign h_w = {1'b0, h};
    assign v_w = {1'b0, v};

    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        h_nxt = h + 11'd1;
        v_nxt = v;
        if (h_w == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_w == V_LAST) ? '0 : v + 11'd1;
        end
    end

    // Decode of the pixel the counters currently hold; registered on the next pix_ce edge.
    always_comb begin
        v_act   = v_w < V_ACT;
        valid_d = (h_w < H_ACT) && v_act;
        x_d     = valid_d ? h : '0;
        y_d     = v_act ? v[9:0] : '0;
        hsync_d = !((h_w >= HS_BEG) && (h_w < HS_END));
        vsync_d = !((v_w >= VS_BEG) && (v_w < VS_END));
        line_d  = (h == '0);
        frame_d = line_d && (v == '0);
    end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar;
    logic [23:0] rgb_d;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to
    // r = ~bar[1], g = ~bar[2], b = ~bar[0].
    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (h_w >= 12'(i * BAR_W)) bar = 3'(i);
        end
        rgb_d = valid_d ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {r, g, b} <= '0;
        end else if (pix_ce) begin
            {r, g, b} <= rgb_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            h           <= '0;
            v           <= '0;
            x           <= '0;
            y           <= '0;
            valid       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            h           <= h_nxt;
            v           <= v_nxt;
            x           <= x_d;
            y           <= y_d;
            valid       <= valid_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            line_start  <= line_d;
            frame_start <= frame_d;
        end else begin
            // Level outputs hold; strobes must not stretch across a stalled cycle.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
